// File: rtl/seq_pkg.sv
// Shared encodings for the serial sequence generator/detector family.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        GAP    = 2'b10,
        FINISH = 2'b11
    } seq_state_t;

    localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/seq_101_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB first, repeated with optional idle gaps.
// First bit appears the cycle after start is accepted; no backpressure, start ignored while busy.
module seq_101_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap_len,
    output logic             seq_out,
    output logic             valid_o,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(PAT_W);
    localparam logic [BW-1:0]    BIT_LAST = BW'(PAT_W - 1);
    localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_t       state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] gap_left_q, gap_left_d;
    logic             seq_q, seq_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pat_d      = pat_q;
        bit_d      = bit_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        gap_left_d = gap_left_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d = pattern;
                    gap_d = gap_len;
                    rep_d = repeat_cnt;
                    if (repeat_cnt == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = SHIFT;
                        shreg_d = pattern;
                        bit_d   = BIT_LAST;
                    end
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
                bit_d   = bit_q - BIT_ONE;
                if (bit_q == '0) begin
                    bit_d = '0;
                    if (rep_q == CNT_ONE) begin
                        state_d = FINISH;
                        rep_d   = '0;
                    end else if (gap_q == '0) begin
                        // Back-to-back repetition: reload without a bubble.
                        shreg_d = pat_q;
                        bit_d   = BIT_LAST;
                        rep_d   = rep_q - CNT_ONE;
                    end else begin
                        state_d    = GAP;
                        gap_left_d = gap_q;
                        rep_d      = rep_q - CNT_ONE;
                    end
                end
            end
            GAP: begin
                if (gap_left_q == CNT_ONE) begin
                    state_d    = SHIFT;
                    shreg_d    = pat_q;
                    bit_d      = BIT_LAST;
                    gap_left_d = '0;
                end else begin
                    gap_left_d = gap_left_q - CNT_ONE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the decode of the next state.
        vld_d  = (state_d == SHIFT);
        seq_d  = vld_d & shreg_d[PAT_W-1];
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            pat_q      <= '0;
            bit_q      <= '0;
            rep_q      <= '0;
            gap_q      <= '0;
            gap_left_q <= '0;
            seq_q      <= 1'b0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pat_q      <= pat_d;
            bit_q      <= bit_d;
            rep_q      <= rep_d;
            gap_q      <= gap_d;
            gap_left_q <= gap_left_d;
            seq_q      <= seq_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seq_out = seq_q;
    assign valid_o = vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_101_gen.sv
// Bench for seq_101_gen: directed and random requests against a cycle-timing model.
module tb_seq_101_gen;
    import seq_pkg::*;

    localparam int PAT_W = 3;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic [CNT_W-1:0] gap_len = '0;
    logic             seq_out, valid_o, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_101_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .seq_out    (seq_out),
        .valid_o    (valid_o),
        .busy       (busy),
        .done       (done)
    );

    function automatic int last_cycle(input int r, input int g);
        return (r == 0) ? 1 : 1 + r * PAT_W + (r - 1) * g;
    endfunction

    // Expected {busy, done, valid, seq} in cycle c, counted from the start edge.
    function automatic logic [3:0] model(input logic [PAT_W-1:0] pat, input int r,
                                         input int g, input int c);
        int last, off;
        last = last_cycle(r, g);
        if (c < 1 || c > last) return 4'b0000;
        if (c == last) return 4'b1100;
        off = (c - 1) % (PAT_W + g);
        if (off < PAT_W) return {3'b101, pat[PAT_W-1-off]};
        return 4'b1000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, done, valid_o, seq_out});
    endfunction

    // Issue one request and check every cycle through the first idle cycle after done.
    task automatic run_req(input logic [PAT_W-1:0] pat, input int r, input int g,
                           input int spur1, input int spur2, output int hits);
        int last, run;
        logic [2:0] hist;
        last = last_cycle(r, g);
        hits = 0;
        run  = 0;
        hist = 3'b000;
        pattern    = pat;
        repeat_cnt = CNT_W'(r);
        gap_len    = CNT_W'(g);
        start      = 1'b1;
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge clock);
            #1;
            start      = (c == spur1) || (c == spur2);
            pattern    = PAT_W'($urandom);
            repeat_cnt = CNT_W'($urandom);
            gap_len    = CNT_W'($urandom);
            chk($sformatf("req pat=%b r=%0d g=%0d cyc=%0d", pat, r, g, c),
                outs(), 32'(model(pat, r, g, c)));
            if (valid_o) begin
                hist = {hist[1:0], seq_out};
                run++;
                if (run >= 3 && hist == 3'b101) hits++;
            end else begin
                run = 0;
            end
        end
    endtask

    initial begin
        int hits, r, g, last, s1, s2;
        logic [PAT_W-1:0] pat;

        #12;
        chk("reset_hold", outs(), 32'd0);
        @(posedge clock);
        #1;
        chk("reset_hold_edge", outs(), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_after_reset", outs(), 32'd0);

        run_req(PAT_101, 1, 0, 0, 0, hits);
        run_req(PAT_101, 3, 0, 0, 0, hits);
        chk("overlap_101_hits", 32'(hits), 32'd3);
        run_req(PAT_101, 2, 2, 0, 0, hits);
        run_req(PAT_101, 0, 0, 0, 0, hits);

        // Spurious starts during SHIFT/GAP/FINISH must be ignored.
        run_req(PAT_101, 1, 0, 2, 4, hits);
        run_req(PAT_101, 2, 2, 4, 9, hits);
        run_req(3'b011, 2, 0, 3, 7, hits);

        // Counter extremes.
        run_req(3'b110, 15, 0, 0, 0, hits);
        run_req(3'b101, 15, 15, 0, 0, hits);

        // Reset asserted in the MSB cycle of repetition 2.
        pattern    = PAT_101;
        repeat_cnt = 4'd3;
        gap_len    = 4'd1;
        start      = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            chk($sformatf("pre_reset cyc=%0d", c), outs(), 32'(model(PAT_101, 3, 1, c)));
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("in_reset_%0d", i), outs(), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_after_midreset", outs(), 32'd0);
        run_req(PAT_101, 3, 1, 0, 0, hits);

        for (int i = 0; i < 25; i++) begin
            pat  = PAT_W'($urandom);
            r    = $urandom_range(0, 5);
            g    = $urandom_range(0, 3);
            last = last_cycle(r, g);
            s1   = $urandom_range(1, last);
            s2   = $urandom_range(1, last);
            run_req(pat, r, g, s1, s2, hits);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_101_gen.md
# seq_101_gen

Serial pattern generator: the transmit-side companion to the team's serial sequence detectors. On a start request it latches a PAT_W-bit pattern and shifts it out MSB first, one bit per clock, repeating it a programmed number of times with an optional idle gap between repetitions. It sits on the stimulus side of a detector link and drives the same one-bit serial line plus a qualifying valid strobe.

## Interface
- PAT_W, default 3: pattern length in bits. Must be at least 2. Default pattern use is 3'b101.
- CNT_W, default 4: width of the repeat and gap counters.

- clock  in  1  rising-edge clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- pattern  in  PAT_W  bits to send; latched on accepted start
- repeat_cnt  in  CNT_W  number of pattern repetitions; latched on accepted start
- gap_len  in  CNT_W  idle cycles between repetitions; latched on accepted start
- seq_out  out  1  serial data; 0 whenever valid_o=0
- valid_o  out  1  seq_out carries a pattern bit this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a request

## Operation
- Moore FSM, 2-bit state, four states:
  - IDLE = 00
  - SHIFT = 01
  - GAP = 10
  - FINISH = 11
- Registers:
  - state
  - shreg[PAT_W-1:0]
  - bit counter
  - rep_left[CNT_W-1:0]
  - gap_left[CNT_W-1:0]
  - latched pat and gap copies
- Accepting a request in IDLE (start=1):
  - Latch pattern, gap_len and repeat_cnt.
  - repeat_cnt=0: go to FINISH. No bits are sent.
  - Otherwise: go to SHIFT with shreg=pattern, bit counter=PAT_W-1, rep_left=repeat_cnt.
- SHIFT:
  - Drives seq_out=shreg[PAT_W-1] and valid_o=1.
  - Shifts left each cycle and decrements the bit counter.
- On the last bit (bit counter=0):
  - rep_left=1: go to FINISH.
  - rep_left>1 and gap=0: reload shreg, decrement rep_left, stay in SHIFT. Output is back-to-back with no bubble.
  - rep_left>1 and gap>0: go to GAP with gap_left=gap and decrement rep_left.
- GAP: holds seq_out=0 and valid_o=0 for gap cycles, then reloads shreg and returns to SHIFT.
- FINISH: done=1 for exactly one cycle, then goes to IDLE.
- start outside IDLE (SHIFT, GAP, FINISH) is ignored and not queued.
- pattern, repeat_cnt and gap_len may change freely after acceptance; only the latched copies are used.
- reset_n low at any time:
  - Immediately forces IDLE.
  - All outputs go to 0 and all counters clear.
  - An in-flight request is abandoned; no done pulse.
- Outputs are decoded from registered state only (Moore); there is no combinational path from inputs to outputs.

## Timing
- Reset values: seq_out=0, valid_o=0, busy=0, done=0, state=IDLE.
- Cycle numbering: start is sampled at edge E0.
  - The first bit (pattern MSB) is valid in the cycle after E0.
  - Bit i of repetition r (r from 0) appears at cycle 1 + r·(PAT_W+gap) + (PAT_W-1-i).
- done is high in cycle 1 + R·PAT_W + (R-1)·gap for R≥1, and in cycle 1 for R=0.
- The next start is accepted at the earliest in the cycle after done, back in IDLE.
- busy rises in cycle 1 and falls together with the exit from FINISH.
- Counters use modular CNT_W arithmetic. The maximum values repeat_cnt=2^CNT_W-1 and gap_len=2^CNT_W-1 must work without wrap.

## Structure
- Shared package seq_pkg holds:
  - State encoding constants IDLE/SHIFT/GAP/FINISH (shared with the detector blocks).
  - Default pattern constant PAT_101 = 3'b101.
- Single module. No sub-module; the counters are small enough to keep inline.

## Test plan
- Reset, then pattern=101, repeat_cnt=1, gap_len=0, start for one cycle:
  - seq_out 1,0,1 with valid_o=1 in cycles 1–3.
  - done=1 in cycle 4; busy high in cycles 1–4.
- pattern=101, repeat_cnt=3, gap_len=0:
  - 9 contiguous valid bits 101101101.
  - An overlapping 101 checker on the line fires exactly 3 times.
  - done in cycle 10.
- pattern=101, repeat_cnt=2, gap_len=2:
  - Cycles 1–3: 1,0,1 with valid=1.
  - Cycles 4–5: valid=0, seq_out=0.
  - Cycles 6–8: 1,0,1.
  - done in cycle 9.
- repeat_cnt=0 with start:
  - valid_o never asserts.
  - done and busy high only in cycle 1; IDLE in cycle 2.
- Second start pulse asserted during SHIFT and during FINISH: ignored. Output is identical to the single-request case, with no extra done.
- reset_n driven low in the middle of bit 2 of repetition 2:
  - All outputs are 0 in the same cycle; busy=0 and no done.
  - After release, a fresh start produces the full sequence from the MSB.
